// File: rtl/morse_key_sequencer.sv
// Morse key front-end: synchronizer, debouncer, dot/dash timing, letter build, commit strobe and hold window.
// Optional word-space emission after a long idle is compiled in when SPACE_EN is defined.
module morse_key_sequencer #(
  parameter int CNT_W    = 27,
  parameter int DEBOUNCE = 500_000,
  parameter int DASH_CYC = 30_000_000,
  parameter int GAP_CYC  = 80_000_000,
  parameter int HOLD_CYC = 1_000_100,
  parameter int WORD_CYC = 200_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key,
  input  logic       clr,
  output logic [4:0] led_morse,
  output logic [2:0] led_cnt,
  output logic       trans,
  output logic       busy,
  output logic       err
);
`ifdef SPACE_EN
  // The word timeout can exceed a CNT_W-bit count, so the shared counter is widened to reach it.
  localparam int WORD_W = $clog2(WORD_CYC + 1);
  localparam int CW     = (WORD_W > CNT_W) ? WORD_W : CNT_W;
  localparam logic [CW-1:0] WORD_LIM = CW'(WORD_CYC - 1);
`else
  localparam int CW = CNT_W;
`endif
  localparam logic [CW-1:0] DB_LIM   = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] DASH_LIM = CW'(DASH_CYC);
  localparam logic [CW-1:0] GAP_LIM  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {IDLE, PRESS, GAP, COMMIT, HOLD} state_t;
  state_t state, state_next;

  logic          sync1, sync2, kd, kd_d;
  logic [CW-1:0] db_cnt, cnt;
  logic          rise, fall, symbol, clr_act, counting;
`ifdef SPACE_EN
  logic          space_armed;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  // kd follows sync2 only after DEBOUNCE consecutive samples that disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      kd     <= 1'b0;
      kd_d   <= 1'b0;
    end else begin
      kd_d <= kd;
      if (sync2 == kd) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LIM) begin
        kd     <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
    end
  end

  assign rise    = kd & ~kd_d;
  assign fall    = ~kd & kd_d;
  assign symbol  = (cnt >= DASH_LIM);
  assign clr_act = clr && ((state == IDLE) || (state == PRESS) || (state == GAP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (clr) state_next = IDLE;
        else if (rise) state_next = PRESS;
`ifdef SPACE_EN
        else if (space_armed && (cnt == WORD_LIM)) state_next = COMMIT;
`endif
      end
      PRESS: begin
        if (clr) state_next = IDLE;
        else if (fall) state_next = (led_cnt == 3'd5) ? IDLE : GAP;
      end
      GAP: begin
        if (clr) state_next = IDLE;
        else if (rise) state_next = PRESS;
        else if (cnt == GAP_LIM) state_next = COMMIT;
      end
      COMMIT: state_next = HOLD;
      HOLD: if (cnt == HOLD_LIM) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    counting = (state == PRESS) || (state == GAP) || (state == HOLD);
`ifdef SPACE_EN
    if ((state == IDLE) && space_armed) counting = 1'b1;
`endif
  end

  // Every state change restarts the shared counter; it saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      led_morse <= '0;
      led_cnt   <= '0;
    end else begin
      if (clr_act || (state_next != state)) cnt <= '0;
      else if (counting && !(&cnt)) cnt <= cnt + CW'(1);

      if (clr_act) begin
        led_morse <= '0;
        led_cnt   <= '0;
      end else if ((state == PRESS) && fall) begin
        if (led_cnt == 3'd5) begin
          led_morse <= '0;
          led_cnt   <= '0;
        end else begin
          led_morse <= {led_morse[3:0], symbol};
          led_cnt   <= led_cnt + 3'd1;
        end
      end else if ((state == HOLD) && (cnt == HOLD_LIM)) begin
        led_morse <= '0;
        led_cnt   <= '0;
      end
    end
  end

`ifdef SPACE_EN
  // A letter commit arms one space; the space commit (led_cnt==0) disarms it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               space_armed <= 1'b0;
    else if (state == COMMIT) space_armed <= (led_cnt != 3'd0);
  end
`endif

  always_comb begin
    trans = (state == COMMIT);
    busy  = (state == COMMIT) || (state == HOLD);
    err   = (state == PRESS) && fall && !clr_act && (led_cnt == 3'd5);
  end

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Randomized bench for morse_key_sequencer: letter-level reference model plus per-cycle output checks.
module tb_morse_key_sequencer;
  localparam int DEBOUNCE = 4;
  localparam int DASH_CYC = 20;
  localparam int GAP_CYC  = 50;
  localparam int HOLD_CYC = 10;
  localparam int WORD_CYC = 100;

  logic       clk = 1'b0;
  logic       rst_n, key, clr;
  logic [4:0] led_morse;
  logic [2:0] led_cnt;
  logic       trans, busy, err;

  morse_key_sequencer #(
    .CNT_W(27), .DEBOUNCE(DEBOUNCE), .DASH_CYC(DASH_CYC),
    .GAP_CYC(GAP_CYC), .HOLD_CYC(HOLD_CYC), .WORD_CYC(WORD_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .clr(clr),
    .led_morse(led_morse), .led_cnt(led_cnt),
    .trans(trans), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_mem [0:255];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         err_exp = 0;
  int         err_seen = 0;
  logic       probe_req = 1'b0;
  logic [7:0] probe_val = 8'h00;
  logic       errc_req = 1'b0;
  int         errc_val = 0;
  logic       final_req = 1'b0;
  logic       final_done = 1'b0;
  logic       prev_busy = 1'b0;
  logic       prev_err = 1'b0;
  int         busy_run = 0;
  logic [7:0] held = 8'h00;
  logic [4:0] cur_morse = 5'd0;
  logic [2:0] cur_cnt = 3'd0;
  logic       armed = 1'b0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Compare process: samples 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        check({led_morse, led_cnt, trans, busy, err} == 11'd0, "reset_outputs",
              {21'd0, led_morse, led_cnt, trans, busy, err}, 0);
        prev_busy = 1'b0;
        prev_err  = 1'b0;
        busy_run  = 0;
      end else begin
        if (busy && !prev_busy) check(trans, "busy_starts_with_trans", {31'd0, trans}, 1);
        if (trans) begin
          check(!prev_busy, "trans_while_busy", {31'd0, prev_busy}, 0);
          if (rd_ptr == wr_ptr) begin
            check(1'b0, "unexpected_trans", {24'd0, led_morse, led_cnt}, 0);
          end else begin
            check({led_morse, led_cnt} == exp_mem[rd_ptr], "commit_code",
                  {24'd0, led_morse, led_cnt}, {24'd0, exp_mem[rd_ptr]});
            $display("commit %0d: led_morse=%b led_cnt=%0d", rd_ptr, led_morse, led_cnt);
            rd_ptr++;
          end
          held     = {led_morse, led_cnt};
          busy_run = 0;
        end
        if (busy) begin
          busy_run++;
          check({led_morse, led_cnt} == held, "hold_frozen", {24'd0, led_morse, led_cnt}, {24'd0, held});
        end else if (prev_busy) begin
          check(busy_run == HOLD_CYC + 1, "busy_len", busy_run, HOLD_CYC + 1);
          check({led_morse, led_cnt} == 8'h00, "cleared_after_hold", {24'd0, led_morse, led_cnt}, 0);
        end
        if (err) begin
          err_seen++;
          check(!prev_err, "err_one_cycle", {31'd0, prev_err}, 0);
        end
        if (probe_req)
          check({led_morse, led_cnt} == probe_val, "probe_led", {24'd0, led_morse, led_cnt}, {24'd0, probe_val});
        if (errc_req) check(err_seen == errc_val, "err_count_point", err_seen, errc_val);
        prev_busy = busy;
        prev_err  = err;
      end
      if (final_req && !final_done) begin
        check(rd_ptr == wr_ptr, "pending_commits", rd_ptr, wr_ptr);
        check(err_seen == err_exp, "err_total", err_seen, err_exp);
        final_done = 1'b1;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presses of 20+ cycles carry a one-cycle bounce that the debouncer must swallow.
  task automatic press(input int n);
    key = 1'b1;
    if (n >= 20) begin
      cyc(10); key = 1'b0; cyc(1); key = 1'b1; cyc(n - 11);
    end else begin
      cyc(n);
    end
    key = 1'b0;
  endtask

  task automatic probe(input logic [7:0] v);
    probe_val = v;
    probe_req = 1'b1;
    cyc(1);
    probe_req = 1'b0;
  endtask

  task automatic probe10();
    cyc(9);
    probe({cur_morse, cur_cnt});
  endtask

  task automatic exp_push(input logic [7:0] v);
    exp_mem[wr_ptr] = v;
    wr_ptr++;
  endtask

  task automatic model_symbol(input bit s);
    if (cur_cnt == 3'd5) begin
      err_exp++;
      cur_morse = 5'd0;
      cur_cnt   = 3'd0;
    end else begin
      cur_morse = {cur_morse[3:0], s};
      cur_cnt   = cur_cnt + 3'd1;
    end
  endtask

  // Called after the post-release probe; long idles are far beyond the word timeout, short ones far below.
  task automatic letter_end(input bit long_idle);
    int r;
    r = long_idle ? int'($urandom_range(200, 260)) : int'($urandom_range(70, 90));
    if (cur_cnt != 3'd0) begin
      exp_push({cur_morse, cur_cnt});
      armed = 1'b1;
    end
    cur_morse = 5'd0;
    cur_cnt   = 3'd0;
`ifdef SPACE_EN
    if (long_idle && armed) begin
      exp_push(8'h00);
      armed = 1'b0;
    end
`endif
    cyc(r - 10);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  nsym, g;
    bit  sym;
    rst_n = 1'b0; key = 1'b0; clr = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(5);

    // Bounce at a 2-cycle period: never accepted.
    for (int i = 0; i < 15; i++) begin
      key = 1'b1; cyc(1); key = 1'b0; cyc(1);
    end
    cyc(40);
    probe(8'h00);

    // Single dot -> E.
    press(10); model_symbol(1'b0); probe10();
    exp_push({5'b00000, 3'd1}); armed = 1'b1; cur_morse = 5'd0; cur_cnt = 3'd0;
    cyc(70);

    // Dot, gap 20, dash -> A.
    press(8); model_symbol(1'b0); probe10(); cyc(10);
    press(30); model_symbol(1'b1); probe10();
    exp_push({5'b00001, 3'd2}); armed = 1'b1; cur_morse = 5'd0; cur_cnt = 3'd0;
    cyc(70);

    // Two dots, then clr held across the next key rise: letter discarded.
    press(8); model_symbol(1'b0); probe10(); cyc(5);
    press(8); model_symbol(1'b0); probe10();
    key = 1'b1; clr = 1'b1; cyc(10);
    clr = 1'b0; cur_morse = 5'd0; cur_cnt = 3'd0; cyc(10);
    key = 1'b0; cyc(50);
    probe(8'h00);

    // Six dots: overflow pulse on the sixth release, no commit.
    for (int i = 0; i < 6; i++) begin
      press(8); model_symbol(1'b0); probe10();
      if (i < 5) cyc(10);
    end
    errc_val = 1; errc_req = 1'b1; cyc(1); errc_req = 1'b0;
    cyc(40);

    // Key pressed during HOLD is ignored; still high on exit, so no symbol.
    press(10); model_symbol(1'b0); probe10();
    exp_push({5'b00000, 3'd1}); armed = 1'b1; cur_morse = 5'd0; cur_cnt = 3'd0;
    cyc(48);
    press(30);
    cyc(30);
    probe(8'h00);

    // E then a long idle: a single space when enabled, nothing more.
    press(8); model_symbol(1'b0); probe10();
    letter_end(1'b1);
    cyc(300);

    // Async reset mid-letter.
    press(8); model_symbol(1'b0); probe10(); cyc(3);
    rst_n = 1'b0; cyc(3); rst_n = 1'b1;
    cur_morse = 5'd0; cur_cnt = 3'd0; armed = 1'b0;
    cyc(10);

    // Async reset mid-HOLD.
    press(8); model_symbol(1'b0); probe10();
    exp_push({5'b00000, 3'd1});
    cur_morse = 5'd0; cur_cnt = 3'd0;
    cyc(55);
    rst_n = 1'b0; cyc(3); rst_n = 1'b1;
    armed = 1'b0;
    cyc(10);

    // Random letters with occasional clr in a gap and occasional long idles.
    for (int l = 0; l < 40; l++) begin
      nsym = int'($urandom_range(1, 6));
      for (int s = 0; s < nsym; s++) begin
        sym = 1'($urandom_range(0, 1));
        press(sym ? int'($urandom_range(28, 40)) : int'($urandom_range(6, 12)));
        model_symbol(sym);
        probe10();
        if (s < nsym - 1) begin
          g = int'($urandom_range(14, 25));
          if ($urandom_range(0, 9) == 0) begin
            clr = 1'b1; cyc(1); clr = 1'b0;
            cur_morse = 5'd0; cur_cnt = 3'd0;
            cyc(g - 11);
          end else begin
            cyc(g - 10);
          end
        end else begin
          letter_end($urandom_range(0, 4) == 0);
        end
      end
    end

    cyc(200);
    final_req = 1'b1;
    for (int i = 0; i < 10 && !final_done; i++) cyc(1);
    if (!final_done) begin
      $display("FAIL final_checks actual=not_run required=run");
      $fatal(1, "final checks not reached");
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
